fetch_stage: RTL

Instruction-fetch stage that owns the architectural PC register and the IF/ID pipeline register. It issues requests to instruction memory over a valid/ready handshake and consumes PC_next, stall and IFIDFlush from the hazard/jump unit. It feeds the current PC back to that unit. A one-entry skid buffer absorbs words that return while decode is stalled, and a drain state discards wrong-path words after a redirect.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the IF/ID register, and issues valid/ready requests to imem.
// Zero-wait memory gives one instruction per cycle; a stall parks the returning word in a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_next,
  input  logic        stall,
  input  logic        IFIDFlush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] redir_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        vld_q;
  logic        take;
  logic [31:0] pc_plus4;

  assign take     = !stall;
  assign pc_plus4 = pc_q + 32'd4;

  // Gated with reset so no request escapes while reset is held.
  assign imem_req         = reset && (state_q != HOLD);
  assign imem_addr        = pc_q;
  assign PC               = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pc4_q;
  assign IFID_Valid       = vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      redir_q <= '0;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (take) begin
              instr_q <= IFIDFlush ? NOP_WORD : imem_rdata;
              pc4_q   <= IFIDFlush ? 32'd0 : pc_plus4;
              vld_q   <= !IFIDFlush;
              pc_q    <= PC_next;
            end else begin
              buf_q   <= imem_rdata;
              state_q <= HOLD;
            end
          end else if (take) begin
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            vld_q   <= 1'b0;
            if (IFIDFlush) begin
              redir_q <= PC_next;
              state_q <= DRAIN;
            end
          end
        end
        HOLD: begin
          if (take) begin
            instr_q <= IFIDFlush ? NOP_WORD : buf_q;
            pc4_q   <= IFIDFlush ? 32'd0 : pc_plus4;
            vld_q   <= !IFIDFlush;
            pc_q    <= PC_next;
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          if (take) begin
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            vld_q   <= 1'b0;
          end
          // The wrong-path word completes the handshake even under stall; holding
          // the stale PC would only re-issue a dead request.
          if (imem_ready) begin
            pc_q    <= (take && IFIDFlush) ? PC_next : redir_q;
            state_q <= FETCH;
          end else if (take && IFIDFlush) begin
            redir_q <= PC_next;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule
